// File: rtl/pipelined_carry_adder_pkg.sv
// Shared definitions for the pipelined carry adder.
// Holds only the mode encoding; widths stay module parameters.
package pipelined_carry_adder_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_t;

endpackage

// File: rtl/pipelined_carry_adder_if.sv
// Operand/result handshake bundle for the pipelined carry adder.
//   x, y, Cin, sub, in_valid     : operand side, driven by the producer
//   in_ready                     : adder can take an operand set this cycle
//   out, Cout, overflow, out_valid : result side, driven by the adder
//   out_ready                    : consumer takes the result this cycle
// master = producer/consumer side, slave = adder side.
interface pipelined_carry_adder_if #(
    parameter int data_width = 32
);
    logic [data_width-1:0] x;
    logic [data_width-1:0] y;
    logic                  Cin;
    logic                  sub;
    logic                  in_valid;
    logic                  in_ready;
    logic [data_width-1:0] out;
    logic                  Cout;
    logic                  overflow;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output x, y, Cin, sub, in_valid, out_ready,
        input  in_ready, out, Cout, overflow, out_valid
    );

    modport slave (
        input  x, y, Cin, sub, in_valid, out_ready,
        output in_ready, out, Cout, overflow, out_valid
    );

endinterface

// File: rtl/pipelined_carry_adder_adder_segment.sv
// Combinational width-bit carry adder used as one pipeline stage slice.
//   a, b  : segment operands
//   cin   : carry into bit 0
//   sum   : segment sum
//   cout  : carry out of the segment MSB
//   cmsb  : carry into the segment MSB (for signed overflow detection)
module adder_segment #(
    parameter int width = 8
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             cin,
    output logic [width-1:0] sum,
    output logic             cout,
    output logic             cmsb
);
    logic [width:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{width{1'b0}}, cin};
    assign sum  = full[width-1:0];
    assign cout = full[width];
    // sum[msb] = a[msb] ^ b[msb] ^ carry_in[msb], so the MSB carry-in can be
    // recovered without a separate narrower adder.
    assign cmsb = full[width-1] ^ a[width-1] ^ b[width-1];

endmodule

// File: rtl/pipelined_carry_adder.sv
// Pipelined ripple-by-segment adder/subtractor with valid/ready handshake.
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of pipelined_carry_adder_if (operands in, result out)
// Stage k adds segment k; operands for higher segments are shifted down
// through skew registers and finished sum segments accumulate in place, so a
// whole result leaves the last stage at once after STAGES advances.
module pipelined_carry_adder #(
    parameter int data_width  = 32,
    parameter int stage_width = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    pipelined_carry_adder_if.slave bus
);
    import pipelined_carry_adder_pkg::*;

    localparam int STAGES = data_width / stage_width;

    mode_t                 mode;
    logic [data_width-1:0] y_eff;
    logic                  c0;
    logic                  advance;

    // Per-stage pipeline registers. x_rem_q/y_rem_q hold the not-yet-added
    // operand bits already shifted down so segment 0 is always next.
    logic [data_width-1:0] sum_q   [STAGES];
    logic [data_width-1:0] x_rem_q [STAGES];
    logic [data_width-1:0] y_rem_q [STAGES];
    logic                  carry_q [STAGES];
    logic                  cmsb_q  [STAGES];
    logic                  valid_q [STAGES];

    assign mode  = mode_t'(bus.sub);
    assign y_eff = (mode == MODE_SUB) ? ~bus.y   : bus.y;
    assign c0    = (mode == MODE_SUB) ? ~bus.Cin : bus.Cin;

    // The whole pipeline moves together; it only stalls when a finished
    // result is waiting and the consumer is not taking it.
    assign bus.in_ready = ~(bus.out_valid & ~bus.out_ready);
    assign advance      = bus.in_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [data_width-1:0]  a_in;
        logic [data_width-1:0]  b_in;
        logic [data_width-1:0]  sum_in;
        logic                   c_in;
        logic                   v_in;
        logic [stage_width-1:0] seg_sum;
        logic                   seg_cout;
        logic                   seg_cmsb;

        if (k == 0) begin : g_head
            assign a_in   = bus.x;
            assign b_in   = y_eff;
            assign sum_in = '0;
            assign c_in   = c0;
            assign v_in   = bus.in_valid;
        end else begin : g_body
            assign a_in   = x_rem_q[k-1];
            assign b_in   = y_rem_q[k-1];
            assign sum_in = sum_q[k-1];
            assign c_in   = carry_q[k-1];
            assign v_in   = valid_q[k-1];
        end

        adder_segment #(
            .width (stage_width)
        ) u_seg (
            .a    (a_in[stage_width-1:0]),
            .b    (b_in[stage_width-1:0]),
            .cin  (c_in),
            .sum  (seg_sum),
            .cout (seg_cout),
            .cmsb (seg_cmsb)
        );

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                valid_q[k] <= 1'b0;
                sum_q[k]   <= '0;
                x_rem_q[k] <= '0;
                y_rem_q[k] <= '0;
                carry_q[k] <= 1'b0;
                cmsb_q[k]  <= 1'b0;
            end else if (advance) begin
                valid_q[k] <= v_in;
                sum_q[k]   <= sum_in | (data_width'(seg_sum) << (k * stage_width));
                x_rem_q[k] <= a_in >> stage_width;
                y_rem_q[k] <= b_in >> stage_width;
                carry_q[k] <= seg_cout;
                cmsb_q[k]  <= seg_cmsb;
            end
        end
    end

    assign bus.out       = sum_q[STAGES-1];
    assign bus.Cout      = carry_q[STAGES-1];
    assign bus.overflow  = carry_q[STAGES-1] ^ cmsb_q[STAGES-1];
    assign bus.out_valid = valid_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Bench for pipelined_carry_adder: three configurations (8/4, 32/8, 8/8)
// share one stimulus stream, each with its own queue scoreboard fed from an
// arithmetic reference model.
module tb_pipelined_carry_adder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] dx = '0;
    logic [31:0] dy = '0;
    logic        dcin = 1'b0;
    logic        dsub = 1'b0;
    logic        dvalid = 1'b0;
    logic        dready = 1'b1;

    int total = 0;
    int bad = 0;

    logic [33:0] q0[$];
    logic [33:0] q1[$];
    logic [33:0] q2[$];
    int          nout[3];
    bit          stall_prev[3];
    logic [33:0] prev_res[3];

    always #5 clk = ~clk;

    pipelined_carry_adder_if #(.data_width(8))  if_a ();
    pipelined_carry_adder_if #(.data_width(32)) if_b ();
    pipelined_carry_adder_if #(.data_width(8))  if_c ();

    assign if_a.x = dx[7:0];  assign if_a.y = dy[7:0];
    assign if_a.Cin = dcin;   assign if_a.sub = dsub;
    assign if_a.in_valid = dvalid; assign if_a.out_ready = dready;
    assign if_b.x = dx;       assign if_b.y = dy;
    assign if_b.Cin = dcin;   assign if_b.sub = dsub;
    assign if_b.in_valid = dvalid; assign if_b.out_ready = dready;
    assign if_c.x = dx[7:0];  assign if_c.y = dy[7:0];
    assign if_c.Cin = dcin;   assign if_c.sub = dsub;
    assign if_c.in_valid = dvalid; assign if_c.out_ready = dready;

    pipelined_carry_adder #(.data_width(8), .stage_width(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(if_a));
    pipelined_carry_adder #(.data_width(32), .stage_width(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(if_b));
    pipelined_carry_adder #(.data_width(8), .stage_width(8)) dut_c (
        .clk(clk), .reset_n(reset_n), .bus(if_c));

    // Result packed as {overflow, Cout, out zero-extended to 32 bits}.
    function automatic logic [33:0] ref_model(input logic [31:0] xv, input logic [31:0] yv,
                                              input bit cin, input bit sb, input int w);
        longint m, xu, yu, ci, u, sx, sy, s;
        bit co, ov;
        logic [31:0] o;
        m  = longint'(1) << w;
        xu = longint'(xv) & (m - 1);
        yu = longint'(yv) & (m - 1);
        ci = cin ? 1 : 0;
        if (sb) begin
            u  = xu - yu - ci;
            co = (xu >= yu + ci);
        end else begin
            u  = xu + yu + ci;
            co = (u >= m);
        end
        sx = (xu >= m / 2) ? xu - m : xu;
        sy = (yu >= m / 2) ? yu - m : yu;
        s  = sb ? (sx - sy - ci) : (sx + sy + ci);
        ov = (s < -(m / 2)) || (s >= m / 2);
        o  = 32'(u & (m - 1));
        return {ov, co, o};
    endfunction

    task automatic chk(input string name, input logic [33:0] got, input logic [33:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int qsize(input int id);
        case (id)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic qpush(input int id, input logic [33:0] v);
        case (id)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic qpop(input int id, output logic [33:0] v);
        case (id)
            0: v = q0.pop_front();
            1: v = q1.pop_front();
            default: v = q2.pop_front();
        endcase
    endtask

    task automatic sb_check(input int id, input bit ov, input bit ordy, input bit iv, input bit ir,
                            input logic [31:0] o, input bit co, input bit of, input int w);
        logic [33:0] got;
        logic [33:0] exp;
        got = {of, co, o};
        chk($sformatf("in_ready dut%0d", id), 34'(ir), 34'(!(ov && !ordy)));
        if (stall_prev[id]) begin
            chk($sformatf("hold_valid dut%0d", id), 34'(ov), 34'(1));
            chk($sformatf("hold_data dut%0d", id), got, prev_res[id]);
        end
        if (ov && ordy) begin
            if (qsize(id) == 0) begin
                chk($sformatf("unexpected_result dut%0d", id), got, 34'h3_FFFF_FFFF);
            end else begin
                qpop(id, exp);
                chk($sformatf("result dut%0d", id), got, exp);
            end
            nout[id]++;
        end
        if (iv && ir) qpush(id, ref_model(dx, dy, dcin, dsub, w));
        stall_prev[id] = ov && !ordy;
        prev_res[id]   = got;
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            sb_check(0, if_a.out_valid, if_a.out_ready, if_a.in_valid, if_a.in_ready,
                     {24'b0, if_a.out}, if_a.Cout, if_a.overflow, 8);
            sb_check(1, if_b.out_valid, if_b.out_ready, if_b.in_valid, if_b.in_ready,
                     if_b.out, if_b.Cout, if_b.overflow, 32);
            sb_check(2, if_c.out_valid, if_c.out_ready, if_c.in_valid, if_c.in_ready,
                     {24'b0, if_c.out}, if_c.Cout, if_c.overflow, 8);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        dvalid = 1'b0;
        dready = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_op(input logic [31:0] a, input logic [31:0] b, input bit c, input bit s);
        dx = a; dy = b; dcin = c; dsub = s; dvalid = 1'b1;
    endtask

    function automatic logic [33:0] res_a();
        return {if_a.overflow, if_a.Cout, 24'b0, if_a.out};
    endfunction

    logic [31:0] bp_x [4] = '{32'h10, 32'h05, 32'hF0, 32'h33};
    logic [31:0] bp_y [4] = '{32'h20, 32'h06, 32'h20, 32'h11};
    bit          bp_s [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [33:0] held;
        int sent;
        int n0;

        for (int i = 0; i < 3; i++) begin
            nout[i] = 0;
            stall_prev[i] = 1'b0;
            prev_res[i] = '0;
        end

        // Pin the model itself with hand-computed values.
        chk("model add 8b", ref_model(32'hFF, 32'h01, 1'b0, 1'b0, 8), {1'b0, 1'b1, 32'h00});
        chk("model sub 8b", ref_model(32'h80, 32'h01, 1'b0, 1'b1, 8), {1'b1, 1'b1, 32'h7F});
        chk("model sub 32b", ref_model(32'h0, 32'h1, 1'b1, 1'b1, 32), {1'b0, 1'b0, 32'hFFFF_FFFE});

        // Reset state.
        step(); step();
        chk("reset out_valid", 34'(if_a.out_valid), 34'(0));
        chk("reset out", res_a(), 34'(0));
        chk("reset in_ready", 34'(if_a.in_ready), 34'(1));
        reset_n = 1'b1;
        idle(3);

        // 0xFF + 0x01: wraps to 0 with carry, no signed overflow, latency 2.
        set_op(32'hFF, 32'h01, 1'b0, 1'b0);
        step();
        dvalid = 1'b0;
        chk("add latency early", 34'(if_a.out_valid), 34'(0));
        step();
        chk("add latency valid", 34'(if_a.out_valid), 34'(1));
        chk("add result", res_a(), {1'b0, 1'b1, 32'h00});
        idle(3);

        // Subtract with overflow, then add with overflow, back to back.
        set_op(32'h80, 32'h01, 1'b0, 1'b1);
        step();
        set_op(32'h7F, 32'h01, 1'b0, 1'b0);
        step();
        dvalid = 1'b0;
        chk("sub ovf valid", 34'(if_a.out_valid), 34'(1));
        chk("sub ovf result", res_a(), {1'b1, 1'b1, 32'h7F});
        step();
        chk("add ovf valid", 34'(if_a.out_valid), 34'(1));
        chk("add ovf result", res_a(), {1'b1, 1'b0, 32'h80});
        idle(4);

        // Backpressure: consumer stalls for 3 cycles while 4 ops stream in.
        n0 = nout[0];
        sent = 0;
        held = '0;
        for (int t = 0; t < 14; t++) begin
            dready = !(t >= 2 && t <= 4);
            if (sent < 4) set_op(bp_x[sent], bp_y[sent], 1'b0, bp_s[sent]);
            else dvalid = 1'b0;
            #1;
            if (t == 2) begin
                chk("bp stall in_ready", 34'(if_a.in_ready), 34'(0));
                chk("bp first result", res_a(), {1'b0, 1'b0, 32'h30});
                held = res_a();
            end
            if (t == 3 || t == 4) begin
                chk("bp stall in_ready", 34'(if_a.in_ready), 34'(0));
                chk("bp held stable", res_a(), held);
            end
            if (dvalid && if_a.in_ready) sent++;
            step();
        end
        chk("bp ops sent", 34'(sent), 34'(4));
        chk("bp results out", 34'(nout[0] - n0), 34'(4));
        idle(4);

        // Bubbles: in_valid alternates, out_valid follows 2 cycles later.
        for (int t = 0; t < 10; t++) begin
            set_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            dvalid = (t % 2 == 0) && (t < 8);
            #1;
            if (t >= 2)
                chk("bubble out_valid", 34'(if_a.out_valid),
                    34'(((t - 2) % 2 == 0) && (t - 2 < 8)));
            step();
        end
        idle(4);

        // Reset with two operations in flight.
        set_op(32'h12, 32'h34, 1'b0, 1'b0);
        step();
        set_op(32'h56, 32'h78, 1'b1, 1'b1);
        step();
        dvalid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst out_valid a", 34'(if_a.out_valid), 34'(0));
        chk("rst out_valid b", 34'(if_b.out_valid), 34'(0));
        chk("rst out_valid c", 34'(if_c.out_valid), 34'(0));
        chk("rst in_ready", 34'(if_a.in_ready), 34'(1));
        chk("rst out", res_a(), 34'(0));
        q0.delete(); q1.delete(); q2.delete();
        for (int i = 0; i < 3; i++) stall_prev[i] = 1'b0;
        step(); step();
        reset_n = 1'b1;
        for (int t = 0; t < 6; t++) begin
            step();
            chk("post rst quiet", 34'({if_a.out_valid, if_b.out_valid, if_c.out_valid}), 34'(0));
        end

        // Random sweep with random bubbles and stalls.
        for (int t = 0; t < 13000; t++) begin
            set_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            dvalid = ($urandom_range(0, 3) != 0);
            dready = ($urandom_range(0, 4) != 0);
            step();
        end
        idle(10);
        chk("drain dut0", 34'(qsize(0)), 34'(0));
        chk("drain dut1", 34'(qsize(1)), 34'(0));
        chk("drain dut2", 34'(qsize(2)), 34'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
